// File: rtl/prores_vlc_codeword_pipe_if.sv
// Stream bundle for the ProRes VLC codeword pipe: input value beats with
// their per-beat codebook, and codeword/length beats out.
interface prores_vlc_codeword_pipe_if #(
  parameter int VAL_W  = 16,
  parameter int CODE_W = 32,
  parameter int LEN_W  = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [VAL_W-1:0]  in_val;
  logic              in_signed;
  logic [2:0]        in_rice_k;
  logic [2:0]        in_exp_k;
  logic [1:0]        in_switch;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_code;
  logic [LEN_W-1:0]  out_len;

  modport master (
    output in_valid, in_val, in_signed, in_rice_k, in_exp_k, in_switch, out_ready,
    input  in_ready, out_valid, out_code, out_len
  );

  modport slave (
    input  in_valid, in_val, in_signed, in_rice_k, in_exp_k, in_switch, out_ready,
    output in_ready, out_valid, out_code, out_len
  );
endinterface

// File: rtl/prores_vlc_codeword_pipe.sv
// ProRes VLC codeword generator: Golomb-Rice prefix region, exp-Golomb escape
// region, optional signed fold. Three lock-step register stages with a global
// enable, plus a running count of emitted bits.
module prores_vlc_codeword_pipe #(
  parameter int VAL_W  = 16,
  parameter int CODE_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic        clk,
  input  logic        reset,
  prores_vlc_codeword_pipe_if.slave s,
  input  logic        clear_count,
  output logic [31:0] total_bits
);
  localparam int FE_W = VAL_W + 11;  // first_exp never overflows at this width
  localparam int W_W  = VAL_W + 1;   // w can exceed VAL_W bits by the (1<<ke) offset

  logic [2:0] vld_pipe;
  logic       en;

  // Whole pipe advances whenever the output slot is free or being drained.
  assign en          = s.out_ready | ~vld_pipe[2];
  assign s.in_ready  = en;
  assign s.out_valid = vld_pipe[2];

  function automatic logic [LEN_W-1:0] msb_idx(input logic [W_W-1:0] x);
    msb_idx = '0;
    for (int i = 0; i < W_W; i++)
      if (x[i]) msb_idx = LEN_W'(i);
  endfunction

  // ---------------- stage 1: fold, first_exp, region select
  logic [VAL_W-1:0] u0;
  logic [FE_W-1:0]  fe0;
  logic             ex0;

  // Fold negative values onto odd codes, then pick the region.
  always_comb begin
    u0  = s.in_signed ? ({s.in_val[VAL_W-2:0], 1'b0} ^ {VAL_W{s.in_val[VAL_W-1]}})
                      : s.in_val;
    fe0 = (FE_W'(s.in_switch) + FE_W'(1)) << s.in_rice_k;
    ex0 = FE_W'(u0) >= fe0;
  end

  logic [VAL_W-1:0] s1_u;
  logic [FE_W-1:0]  s1_fe;
  logic             s1_ex;
  logic [2:0]       s1_kr, s1_ke;
  logic [1:0]       s1_sb;

  // Stage 1 register; codebook rides along with the value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_u <= '0; s1_fe <= '0; s1_ex <= 1'b0;
      s1_kr <= '0; s1_ke <= '0; s1_sb <= '0;
    end else if (en) begin
      s1_u <= u0; s1_fe <= fe0; s1_ex <= ex0;
      s1_kr <= s.in_rice_k; s1_ke <= s.in_exp_k; s1_sb <= s.in_switch;
    end
  end

  // ---------------- stage 2: quotient / escape value and its exponent
  logic [FE_W-1:0]  wfull;
  logic [W_W-1:0]   w1;
  logic [VAL_W-1:0] q1;
  logic [LEN_W-1:0] e1;

  // w is only meaningful in the exp region, where u >= first_exp.
  always_comb begin
    wfull = FE_W'(s1_u) - s1_fe + (FE_W'(1) << s1_ke);
    w1    = W_W'(wfull);
    q1    = s1_u >> s1_kr;
    e1    = msb_idx(w1);
  end

  logic [W_W-1:0]   s2_w;
  logic [LEN_W-1:0] s2_q, s2_e;
  logic [6:0]       s2_rlo;
  logic             s2_ex;
  logic [2:0]       s2_kr, s2_ke;
  logic [1:0]       s2_sb;

  // Stage 2 register; in the Rice region q <= sb, so a short copy suffices.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_w <= '0; s2_q <= '0; s2_e <= '0; s2_rlo <= '0; s2_ex <= 1'b0;
      s2_kr <= '0; s2_ke <= '0; s2_sb <= '0;
    end else if (en) begin
      s2_w <= w1; s2_q <= LEN_W'(q1); s2_e <= e1; s2_rlo <= s1_u[6:0]; s2_ex <= s1_ex;
      s2_kr <= s1_kr; s2_ke <= s1_ke; s2_sb <= s1_sb;
    end
  end

  // ---------------- stage 3: codeword and length
  logic [7:0]        mask;
  logic [CODE_W-1:0] code2;
  logic [LEN_W-1:0]  len2;

  // Rice: stop bit plus kr suffix bits; exp: w itself with (e-ke+sb) prefix zeros.
  always_comb begin
    mask = (8'd1 << s2_kr) - 8'd1;
    if (s2_ex) begin
      code2 = CODE_W'(s2_w);
      len2  = (s2_e - LEN_W'(s2_ke) + LEN_W'(s2_sb)) + (s2_e + LEN_W'(1));
    end else begin
      code2 = CODE_W'((8'd1 << s2_kr) | ({1'b0, s2_rlo} & mask));
      len2  = s2_q + LEN_W'(1) + LEN_W'(s2_kr);
    end
  end

  // Output register doubles as stage 3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s.out_code <= '0;
      s.out_len  <= '0;
    end else if (en) begin
      s.out_code <= code2;
      s.out_len  <= len2;
    end
  end

  // Stage valids shift in lock-step with the data; bubbles stay in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   vld_pipe <= '0;
    else if (en) vld_pipe <= {vld_pipe[1:0], s.in_valid};
  end

  // Running bit count; a coincident clear keeps only the current transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) total_bits <= '0;
    else if (clear_count)
      total_bits <= (s.out_valid & s.out_ready) ? 32'(s.out_len) : 32'd0;
    else if (s.out_valid & s.out_ready)
      total_bits <= total_bits + 32'(s.out_len);
  end
endmodule

// File: tb/tb_prores_vlc_codeword_pipe.sv
// Directed bench for prores_vlc_codeword_pipe with hand-computed vectors.
module tb_prores_vlc_codeword_pipe;
  logic        clk;
  logic        reset;
  logic        clear_count;
  logic [31:0] total_bits;
  int          n_cmp;
  int          n_bad;

  prores_vlc_codeword_pipe_if #(.VAL_W(16), .CODE_W(32), .LEN_W(6)) bus ();

  prores_vlc_codeword_pipe #(.VAL_W(16), .CODE_W(32), .LEN_W(6)) dut (
    .clk(clk), .reset(reset), .s(bus), .clear_count(clear_count), .total_bits(total_bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector table: value, signed, kr, ke, sb -> code, len (computed by hand)
  logic [15:0] t_val  [9];
  logic        t_sg   [9];
  logic [2:0]  t_kr   [9];
  logic [2:0]  t_ke   [9];
  logic [1:0]  t_sb   [9];
  logic [31:0] t_code [9];
  logic [5:0]  t_len  [9];

  task automatic set_beat(input int i);
    bus.in_val    = t_val[i];
    bus.in_signed = t_sg[i];
    bus.in_rice_k = t_kr[i];
    bus.in_exp_k  = t_ke[i];
    bus.in_switch = t_sb[i];
    bus.in_valid  = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_code !== 32'd0) begin n_bad++; $display("FAIL reset_out_code got %0d want 0", bus.out_code); end
    n_cmp++; if (bus.out_len !== 6'd0) begin n_bad++; $display("FAIL reset_out_len got %0d want 0", bus.out_len); end
    n_cmp++; if (total_bits !== 32'd0) begin n_bad++; $display("FAIL reset_total got %0d want 0", total_bits); end
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_rice_latency();
    set_beat(0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_n0 out_valid got %b want 0", bus.out_valid); end
    @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_n1 out_valid got %b want 0", bus.out_valid); end
    @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL lat_n2 out_valid got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_code !== 32'd5) begin n_bad++; $display("FAIL rice_code got %0d want 5", bus.out_code); end
    n_cmp++; if (bus.out_len !== 6'd4) begin n_bad++; $display("FAIL rice_len got %0d want 4", bus.out_len); end
    @(posedge clk); #1;
    n_cmp++; if (total_bits !== 32'd4) begin n_bad++; $display("FAIL rice_total got %0d want 4", total_bits); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rice_drain out_valid got %b want 0", bus.out_valid); end
  endtask

  // Streams table entries [start, start+n) back to back and expects one
  // output per cycle starting two edges after the first acceptance.
  task automatic test_stream(input int start, input int n, input string name);
    for (int cyc = 0; cyc < n + 2; cyc++) begin
      if (cyc < n) set_beat(start + cyc);
      else bus.in_valid = 1'b0;
      @(posedge clk); #1;
      if (cyc >= 2) begin
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL %s_valid[%0d] got %b want 1", name, cyc - 2, bus.out_valid); end
        n_cmp++; if (bus.out_code !== t_code[start + cyc - 2]) begin n_bad++; $display("FAIL %s_code[%0d] got %0d want %0d", name, cyc - 2, bus.out_code, t_code[start + cyc - 2]); end
        n_cmp++; if (bus.out_len !== t_len[start + cyc - 2]) begin n_bad++; $display("FAIL %s_len[%0d] got %0d want %0d", name, cyc - 2, bus.out_len, t_len[start + cyc - 2]); end
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int idx_in, idx_out, cycles;
    logic acc, xfer;
    clear_count = 1'b1;
    @(posedge clk); #1;
    clear_count = 1'b0;
    n_cmp++; if (total_bits !== 32'd0) begin n_bad++; $display("FAIL bp_clear_total got %0d want 0", total_bits); end
    idx_in = 0; idx_out = 0; cycles = 0;
    while (idx_out < 8 && cycles < 200) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (idx_in < 8) set_beat(idx_in);
      else bus.in_valid = 1'b0;
      #3;
      acc  = bus.in_valid & bus.in_ready;
      xfer = bus.out_valid & bus.out_ready;
      if (bus.out_valid) begin
        n_cmp++; if (bus.out_code !== t_code[idx_out]) begin n_bad++; $display("FAIL bp_code[%0d] got %0d want %0d", idx_out, bus.out_code, t_code[idx_out]); end
        n_cmp++; if (bus.out_len !== t_len[idx_out]) begin n_bad++; $display("FAIL bp_len[%0d] got %0d want %0d", idx_out, bus.out_len, t_len[idx_out]); end
        if (!bus.out_ready) begin
          n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_stall_in_ready got %b want 0", bus.in_ready); end
        end
      end
      @(posedge clk); #1;
      if (acc) idx_in++;
      if (xfer) idx_out++;
      cycles++;
    end
    n_cmp++; if (idx_out != 8) begin n_bad++; $display("FAIL bp_timeout got %0d beats want 8", idx_out); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_extra_beat got %b want 0", bus.out_valid); end
    end
    n_cmp++; if (total_bits !== 32'd67) begin n_bad++; $display("FAIL bp_total got %0d want 67", total_bits); end
  endtask

  task automatic test_counter_clear();
    clear_count = 1'b1;
    @(posedge clk); #1;
    clear_count = 1'b0;
    n_cmp++; if (total_bits !== 32'd0) begin n_bad++; $display("FAIL clr_idle_total got %0d want 0", total_bits); end
    set_beat(1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear_count = 1'b1;
    @(posedge clk); #1;
    clear_count = 1'b0;
    n_cmp++; if (total_bits !== 32'd7) begin n_bad++; $display("FAIL clr_xfer_total got %0d want 7", total_bits); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      set_beat(i);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_code !== 32'd0) begin n_bad++; $display("FAIL mid_rst_code got %0d want 0", bus.out_code); end
    n_cmp++; if (bus.out_len !== 6'd0) begin n_bad++; $display("FAIL mid_rst_len got %0d want 0", bus.out_len); end
    n_cmp++; if (total_bits !== 32'd0) begin n_bad++; $display("FAIL mid_rst_total got %0d want 0", total_bits); end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_stale_beat[%0d] got %b want 0", i, bus.out_valid); end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    //            u=5    u=20   u=15   -3        3      FFFF      0      16     -32768
    t_val  = '{16'd5, 16'd20, 16'd15, 16'hFFFD, 16'd3, 16'hFFFF, 16'd0, 16'd16, 16'h8000};
    t_sg   = '{1'b0,  1'b0,   1'b0,   1'b1,     1'b1,  1'b0,     1'b0,  1'b0,   1'b1};
    t_kr   = '{3'd2,  3'd2,   3'd2,   3'd2,     3'd2,  3'd0,     3'd0,  3'd2,   3'd0};
    t_ke   = '{3'd3,  3'd3,   3'd3,   3'd3,     3'd3,  3'd0,     3'd0,  3'd3,   3'd0};
    t_sb   = '{2'd3,  2'd3,   2'd3,   2'd3,     2'd3,  2'd3,     2'd0,  2'd3,   2'd3};
    t_code = '{32'd5, 32'd12, 32'd7,  32'd5,    32'd6, 32'd65532, 32'd1, 32'd8, 32'd65532};
    t_len  = '{6'd4,  6'd7,   6'd6,   6'd4,     6'd4,  6'd34,    6'd1,  6'd7,   6'd34};

    clear_count   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_val    = '0;
    bus.in_signed = 1'b0;
    bus.in_rice_k = '0;
    bus.in_exp_k  = '0;
    bus.in_switch = '0;
    bus.out_ready = 1'b1;

    test_reset();
    test_rice_latency();
    test_stream(1, 2, "exp");
    test_stream(3, 2, "fold");
    test_stream(5, 2, "extreme");
    test_stream(8, 1, "fold_min");
    test_stream(0, 8, "back_to_back");
    test_backpressure();
    test_counter_clear();
    test_reset_midstream();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
